// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment display path.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned SEG_W      = 7;

    // Segment order is {g,f,e,d,c,b,a}, active-low
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    localparam logic [SEG_W-1:0] SEG_DIGITS [0:9] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

    function automatic logic [NUM_DIGITS-1:0] onehot4(input logic [1:0] idx);
        return NUM_DIGITS'(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seven_segment_decoder.sv
// Combinational BCD to active-low seven-segment decode; non-BCD codes go dark.
module seven_segment_decoder
    import seg7_pkg::*;
(
    input  logic [3:0]       i_bcd,
    output logic [SEG_W-1:0] o_seg_c
);

    always_comb begin
        o_seg_c = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg_c = SEG_DIGITS[0];
            4'd1:    o_seg_c = SEG_DIGITS[1];
            4'd2:    o_seg_c = SEG_DIGITS[2];
            4'd3:    o_seg_c = SEG_DIGITS[3];
            4'd4:    o_seg_c = SEG_DIGITS[4];
            4'd5:    o_seg_c = SEG_DIGITS[5];
            4'd6:    o_seg_c = SEG_DIGITS[6];
            4'd7:    o_seg_c = SEG_DIGITS[7];
            4'd8:    o_seg_c = SEG_DIGITS[8];
            4'd9:    o_seg_c = SEG_DIGITS[9];
            default: o_seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode driver with blanking, leading-zero
// suppression, decimal points and frame-coherent shadow capture.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100_000,
    parameter int unsigned BLANK_CYCLES = 1_000,
    parameter int unsigned LZ_BLANK     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [15:0]           bcd,
    input  logic [NUM_DIGITS-1:0] dp_in,
    output logic [SEG_W-1:0]      seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  frame_tick
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam bit          LZ_EN = (LZ_BLANK != 0);

    logic [CNT_W-1:0]      r_div_cnt,    w_div_cnt_nxt;
    logic [1:0]            r_idx,        w_idx_nxt;
    logic [15:0]           r_shadow_bcd, w_shadow_bcd_nxt;
    logic [NUM_DIGITS-1:0] r_shadow_dp,  w_shadow_dp_nxt;
    logic                  r_frame_tick, w_frame_tick_nxt;
    logic [NUM_DIGITS-1:0] r_an,         w_an_nxt;
    logic [SEG_W-1:0]      r_seg,        w_seg_nxt;
    logic                  r_dp,         w_dp_nxt;

    logic                  w_wrap;
    logic                  w_active;
    logic [3:0]            w_digit;
    logic [SEG_W-1:0]      w_dec_seg;
    logic [NUM_DIGITS-1:0] w_zero;
    logic [NUM_DIGITS-1:0] w_lz;

    assign w_wrap   = (r_div_cnt == CNT_W'(REFRESH_DIV - 1));
    assign w_active = en && (r_div_cnt >= CNT_W'(BLANK_CYCLES));
    assign w_digit  = r_shadow_bcd[{r_idx, 2'b00} +: 4];

    seven_segment_decoder u_decoder (
        .i_bcd   (w_digit),
        .o_seg_c (w_dec_seg)
    );

    // A digit is a leading zero when it and every digit to its left are zero
    always_comb begin
        w_zero = '0;
        w_lz   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_zero[i] = (r_shadow_bcd[i*4 +: 4] == 4'd0);
        end
        if (LZ_EN) begin
            w_lz[3] = w_zero[3];
            w_lz[2] = w_zero[3] & w_zero[2];
            w_lz[1] = w_zero[3] & w_zero[2] & w_zero[1];
        end
    end

    always_comb begin
        w_div_cnt_nxt    = r_div_cnt + CNT_W'(1);
        w_idx_nxt        = r_idx;
        w_shadow_bcd_nxt = r_shadow_bcd;
        w_shadow_dp_nxt  = r_shadow_dp;
        w_frame_tick_nxt = 1'b0;
        w_an_nxt         = '0;
        w_seg_nxt        = SEG_BLANK;
        w_dp_nxt         = 1'b1;

        if (w_wrap) begin
            w_div_cnt_nxt = '0;
            w_idx_nxt     = r_idx + 2'd1;
            // Capture at the frame boundary so a frame never mixes old and new digits
            if (r_idx == 2'd3) begin
                w_shadow_bcd_nxt = bcd;
                w_shadow_dp_nxt  = dp_in;
                w_frame_tick_nxt = 1'b1;
            end
        end

        if (w_active) begin
            w_an_nxt  = onehot4(r_idx);
            w_seg_nxt = w_lz[r_idx] ? SEG_BLANK : w_dec_seg;
            w_dp_nxt  = ~r_shadow_dp[r_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt    <= '0;
            r_idx        <= '0;
            r_shadow_bcd <= '0;
            r_shadow_dp  <= '0;
            r_frame_tick <= 1'b0;
            r_an         <= '0;
            r_seg        <= SEG_BLANK;
            r_dp         <= 1'b1;
        end else begin
            r_div_cnt    <= w_div_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_shadow_bcd <= w_shadow_bcd_nxt;
            r_shadow_dp  <= w_shadow_dp_nxt;
            r_frame_tick <= w_frame_tick_nxt;
            r_an         <= w_an_nxt;
            r_seg        <= w_seg_nxt;
            r_dp         <= w_dp_nxt;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed scoreboard bench for seg7_scan_driver (REFRESH_DIV=8, BLANK_CYCLES=2).
module tb_seg7_scan_driver;

    localparam int unsigned RDIV  = 8;
    localparam int unsigned BLANK = 2;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] bcd;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    int n_cmp;
    int n_err;
    int cyc;

    // Bench-side reference state: slot position and captured frame
    int          m_cnt;
    int          m_idx;
    logic [15:0] m_sh;
    logic [3:0]  m_shdp;

    logic [12:0] sb_q [$];

    seg7_scan_driver #(
        .REFRESH_DIV  (RDIV),
        .BLANK_CYCLES (BLANK),
        .LZ_BLANK     (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .bcd        (bcd),
        .dp_in      (dp_in),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] ref_dec(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected {an, seg, dp, frame_tick} after the coming edge
    function automatic logic [12:0] ref_out();
        logic [3:0]  a;
        logic [6:0]  s;
        logic        d;
        logic        t;
        logic [3:0]  dig;
        logic [15:0] upper;
        a = 4'b0000;
        s = 7'b1111111;
        d = 1'b1;
        t = (m_cnt == RDIV - 1) && (m_idx == 3);
        if (en && m_cnt >= BLANK) begin
            a     = 4'(1 << m_idx);
            dig   = m_sh[m_idx*4 +: 4];
            upper = m_sh >> (m_idx * 4);
            s     = (m_idx != 0 && upper == 16'h0) ? 7'b1111111 : ref_dec(dig);
            d     = ~m_shdp[m_idx];
        end
        return {a, s, d, t};
    endfunction

    task automatic ref_reset();
        m_cnt  = 0;
        m_idx  = 0;
        m_sh   = 16'h0;
        m_shdp = 4'h0;
    endtask

    task automatic ref_advance();
        if (m_cnt == RDIV - 1) begin
            m_cnt = 0;
            if (m_idx == 3) begin
                m_sh   = bcd;
                m_shdp = dp_in;
            end
            m_idx = (m_idx + 1) % 4;
        end else begin
            m_cnt = m_cnt + 1;
        end
    endtask

    task automatic step();
        logic [12:0] got;
        logic [12:0] exp_v;
        sb_q.push_back(ref_out());
        @(posedge clk);
        ref_advance();
        #1;
        cyc++;
        got   = {an, seg, dp, frame_tick};
        exp_v = sb_q.pop_front();
        n_cmp++;
        assert (got === exp_v) else begin
            n_err++;
            $error("FAIL out cyc=%0d an/seg/dp/tick observed=%b_%b_%b_%b expected=%b_%b_%b_%b",
                   cyc, got[12:9], got[8:2], got[1], got[0],
                   exp_v[12:9], exp_v[8:2], exp_v[1], exp_v[0]);
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic check_blank(input string tag);
        n_cmp++;
        assert ({an, seg, dp, frame_tick} === {4'b0000, 7'b1111111, 1'b1, 1'b0}) else begin
            n_err++;
            $error("FAIL %s observed=%b_%b_%b_%b expected=0000_1111111_1_0",
                   tag, an, seg, dp, frame_tick);
        end
    endtask

    task automatic run_to_cnt(input int c);
        for (int k = 0; k < 4 * RDIV && m_cnt != c; k++) step();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        rst_n = 1'b0;
        en    = 1'b1;
        bcd   = 16'h1234;
        dp_in = 4'b0000;
        ref_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_blank("reset");
        rst_n = 1'b1;

        // Frame 0 shows the zero shadow, then two frames of 1234
        run(3 * 4 * RDIV);

        // Inner zero kept, leading zeros dark
        bcd = 16'h0050;
        run(2 * 4 * RDIV);

        // All-zero value with a dp on a leading-zero-blanked digit
        bcd   = 16'h0000;
        dp_in = 4'b0100;
        run(2 * 4 * RDIV);

        // Mid-frame change must not tear the frame in flight
        bcd   = 16'h1234;
        dp_in = 4'b0000;
        run(2 * 4 * RDIV);
        run(RDIV + 3);
        bcd = 16'h5678;
        run(3 * RDIV - 3 + 4 * RDIV);

        // Non-BCD digits go dark
        bcd = 16'hFA00;
        run(2 * 4 * RDIV);

        // Enable drop mid-active-slot and resume
        bcd = 16'h1234;
        run(4 * RDIV);
        run_to_cnt(4);
        en = 1'b0;
        run(2 * RDIV + 3);
        en = 1'b1;
        run(4 * RDIV);

        // Asynchronous reset mid-slot
        run_to_cnt(5);
        rst_n = 1'b0;
        #1;
        check_blank("async_rst");
        ref_reset();
        @(posedge clk);
        #1;
        check_blank("rst_hold");
        rst_n = 1'b1;
        run(2 * 4 * RDIV);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Drives a 4-digit common-anode seven-segment display by time-multiplexing four BCD digits onto one shared segment bus.
- Sits downstream of the team's digit counters and replaces the fixed single-anode hookup.
- Digit decode uses the existing seven_segment_decoder.
- Adds inter-digit blanking (anti-ghosting), leading-zero suppression, per-digit decimal points and frame-coherent input capture.

Parameters:
REFRESH_DIV, 100_000, clk cycles per digit slot (≥ BLANK_CYCLES+2); 1 ms per digit at 100 MHz.
BLANK_CYCLES, 1_000, cycles at the start of each slot with all anodes off.
LZ_BLANK, 1, 1 enables leading-zero suppression; 0 always shows every digit.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  display enable; 0 forces all anodes off
bcd  input  16  four BCD digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3
dp_in  input  4  decimal-point request per digit, active-high; bit i maps to digit i
seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal-point drive, active-low
an  output  4  anode select, active-high one-hot; bit i maps to digit i
frame_tick  output  1  one-cycle pulse marking a shadow-register capture

Behaviour:
- Reset (async assert, sync release on clk):
  - div_cnt=0, idx=0, shadow_bcd=0, shadow_dp=0.
  - an=4'b0000, seg=7'b1111111, dp=1, frame_tick=0.
- Slot timer:
  - div_cnt counts 0..REFRESH_DIV-1, then wraps to 0.
  - On wrap, idx advances 0→1→2→3→0.
  - Timer and idx run regardless of en.
- Shadow capture:
  - On the cycle div_cnt wraps with idx==3, shadow_bcd<=bcd, shadow_dp<=dp_in and frame_tick<=1 for exactly that cycle.
  - The first capture after reset occurs at the end of the first idx==3 slot. Until then the shadow holds 0.
  - bcd/dp_in changes mid-frame never appear until the next capture (no tearing).
- Output phase within a slot, computed from the current div_cnt/idx and registered (1 cycle latency):
  - div_cnt < BLANK_CYCLES → an=0000, seg=1111111, dp=1.
  - Otherwise → an=one-hot(idx), seg=decode(shadow digit idx), dp=~shadow_dp[idx].
- Digit blanking, where blanked means seg=1111111 with the anode still driven:
  - A shadow digit > 9 is blanked (decoder default).
  - With LZ_BLANK=1, digit i (i=3,2,1) is blanked when it and every higher digit equal 0.
  - Digit 0 is never leading-zero blanked.
  - A leading-zero-blanked digit still shows its dp if requested.
- en=0 → an=0000, seg=1111111, dp=1 from the next cycle. en=1 resumes at the current slot position, with normal blanking rules.
- Simultaneous wrap and capture: the new shadow applies to the idx==0 slot that begins on the same edge; its blank interval hides the change.
- Reset mid-slot returns to idx=0, div_cnt=0 and blank outputs immediately (async).
- Widths:
  - div_cnt is clog2(REFRESH_DIV) bits.
  - idx is 2 bits and wraps naturally.
  - No arithmetic overflow is possible.

Decomposition:
- Package seg7_pkg holds:
  - SEG_BLANK=7'b1111111.
  - Active-low digit patterns 0–9 (single source for the decoder).
  - NUM_DIGITS=4.
  - The function onehot4(idx).
- Sub-module: one combinational seven_segment_decoder instance, fed by a 4:1 mux of shadow_bcd on idx.
- The timer, shadow register, LZ logic and output registers stay in seg7_scan_driver.

Test Plan:
- Bench parameters for all scenarios: REFRESH_DIV=8, BLANK_CYCLES=2, LZ_BLANK=1.
- Reset, then hold bcd=16'h1234, dp_in=0, en=1 for 2 frames → after the first frame_tick:
  - an sequence 0001,0010,0100,1000.
  - Each slot shows 2 cycles an=0000 and 6 cycles active.
  - seg per slot: 4→0011001, 3→0110000, 2→0100100, 1→1111001.
  - frame_tick fires every 32 cycles.
- bcd=16'h0050 → digit 3 and digit 2 show seg=1111111 with anode on; digit 1=0010010; digit 0=1000000 (the inner zero is not blanked).
- bcd=16'h0000, dp_in=4'b0100 → digits 3..1 blank; digit 2 dp=0; digit 0 shows 1000000.
- Change bcd from 1234 to 5678 during the idx==1 slot → remaining slots of that frame still show 1234; the next frame shows 5678.
- bcd=16'hFA00 → digits 3 and 2 blank (>9); digits 1 and 0 show 1000000.
- Deassert en mid-active slot → an=0000, seg=1111111 on the next cycle while idx keeps advancing. Assert rst_n=0 mid-slot → outputs blank immediately, and idx restarts at 0 after release.
